// File: rtl/sram_uart_tx_dump_pkg.sv
// Shared state typedef and line-level constants for the SRAM-to-UART dump path.
// Optional feature macro: UART_TX_CHECKSUM_EN adds the S_TX_CHKSUM state.
package sram_uart_tx_dump_pkg;

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned BYTE_W = 8;

  localparam logic UART_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    S_TX_IDLE,
    S_TX_RD_ADDR,
    S_TX_RD_WAIT,
    S_TX_SEND_HI,
    S_TX_SEND_LO,
`ifdef UART_TX_CHECKSUM_EN
    S_TX_CHKSUM,
`endif
    S_TX_DONE
  } tx_state_type;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: owns the baud counter and bit index.
// Ready is high during the last cycle of the stop bit; a Load in that cycle
// starts the next start bit with no idle gap.
module uart_tx_byte
  import sram_uart_tx_dump_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Load,
  input  logic [BYTE_W-1:0] Data,
  output logic              Tx,
  output logic              Ready
);

  localparam int unsigned CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned LAST_BIT = 9;

  logic              r_active;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_bit;
  logic [BYTE_W-1:0] r_shift;
  logic              r_tx;
  logic              r_ready;

  logic              w_bit_end;
  logic              w_accept;
  logic              w_nxt_active;
  logic [CNT_W-1:0]  w_nxt_cnt;
  logic [3:0]        w_nxt_bit;

  // Next baud-counter / bit-index state
  always_comb begin
    w_bit_end    = r_active && (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
    w_accept     = Load && (!r_active || r_ready);
    w_nxt_active = r_active;
    w_nxt_cnt    = r_cnt;
    w_nxt_bit    = r_bit;
    if (w_accept) begin
      w_nxt_active = 1'b1;
      w_nxt_cnt    = '0;
      w_nxt_bit    = '0;
    end else if (w_bit_end) begin
      w_nxt_cnt = '0;
      if (r_bit == 4'(LAST_BIT)) begin
        w_nxt_active = 1'b0;
      end else begin
        w_nxt_bit = r_bit + 4'd1;
      end
    end else if (r_active) begin
      w_nxt_cnt = r_cnt + CNT_W'(1);
    end
  end

  // Line register, shift register and look-ahead Ready flag
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_tx     <= UART_IDLE;
      r_ready  <= 1'b0;
    end else begin
      r_active <= w_nxt_active;
      r_cnt    <= w_nxt_cnt;
      r_bit    <= w_nxt_bit;
      r_ready  <= w_nxt_active && (w_nxt_bit == 4'(LAST_BIT)) &&
                  (w_nxt_cnt == CNT_W'(CLKS_PER_BIT - 1));
      if (w_accept) begin
        r_shift <= Data;
        r_tx    <= START_BIT;
      end else if (w_bit_end) begin
        if (r_bit == 4'(LAST_BIT)) begin
          r_tx <= UART_IDLE;
        end else if (r_bit == 4'(LAST_BIT - 1)) begin
          r_tx <= STOP_BIT;
        end else begin
          r_tx    <= r_shift[0];
          r_shift <= {1'b0, r_shift[BYTE_W-1:1]};
        end
      end
    end
  end

  assign Tx    = r_tx;
  assign Ready = r_ready;

endmodule

// File: rtl/sram_uart_tx_dump.sv
// Dumps Word_count 16-bit SRAM words starting at Base_address out of the UART,
// high byte first. Optional macro UART_TX_CHECKSUM_EN appends an 8-bit sum byte.
module sram_uart_tx_dump
  import sram_uart_tx_dump_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned SRAM_RD_LAT  = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Base_address,
  input  logic [ADDR_W-1:0] Word_count,
  input  logic [DATA_W-1:0] SRAM_read_data,
  output logic [ADDR_W-1:0] SRAM_address,
  output logic              SRAM_we_n,
  output logic              UART_TX_O,
  output logic              Busy,
  output logic              Done
);

  localparam int unsigned WAIT_W = (SRAM_RD_LAT > 1) ? $clog2(SRAM_RD_LAT) : 1;

  tx_state_type      r_state;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_sram_address;
  logic [ADDR_W-1:0] r_remaining;
  logic [WAIT_W-1:0] r_wait;
  logic [DATA_W-1:0] r_word;
  logic              r_hi_loaded;
`ifdef UART_TX_CHECKSUM_EN
  logic [BYTE_W-1:0] r_sum;
  logic              w_load_chk;
`endif

  logic              w_load;
  logic [BYTE_W-1:0] w_tx_data;
  logic              w_ready;
  logic              w_tx;
  logic              w_start_ok;

  // A Start coinciding with the Done pulse is dropped
  assign w_start_ok = Start && !r_done;

  // Byte load strobe and data into the serializer
  always_comb begin
    w_load    = 1'b0;
    w_tx_data = '0;
`ifdef UART_TX_CHECKSUM_EN
    w_load_chk = 1'b0;
`endif
    case (r_state)
      S_TX_SEND_HI: begin
        if (!r_hi_loaded) begin
          w_load    = 1'b1;
          w_tx_data = r_word[15:8];
        end else if (w_ready) begin
          w_load    = 1'b1;
          w_tx_data = r_word[7:0];
        end
      end
`ifdef UART_TX_CHECKSUM_EN
      S_TX_IDLE: begin
        if (w_start_ok && (Word_count == '0)) begin
          w_load     = 1'b1;
          w_load_chk = 1'b1;
        end
      end
      S_TX_SEND_LO: begin
        if (w_ready && (r_remaining == ADDR_W'(1))) begin
          w_load     = 1'b1;
          w_load_chk = 1'b1;
          w_tx_data  = r_sum;
        end
      end
`endif
      default: ;
    endcase
  end

  // Dump sequencer: SRAM read, two bytes per word, completion pulse
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state        <= S_TX_IDLE;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_sram_address <= '0;
      r_remaining    <= '0;
      r_wait         <= '0;
      r_word         <= '0;
      r_hi_loaded    <= 1'b0;
`ifdef UART_TX_CHECKSUM_EN
      r_sum          <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_TX_IDLE: begin
          if (w_start_ok) begin
            r_busy         <= 1'b1;
            r_sram_address <= Base_address;
            r_remaining    <= Word_count;
`ifdef UART_TX_CHECKSUM_EN
            r_sum          <= '0;
            r_state        <= (Word_count == '0) ? S_TX_CHKSUM : S_TX_RD_ADDR;
`else
            r_state        <= (Word_count == '0) ? S_TX_DONE : S_TX_RD_ADDR;
`endif
          end
        end
        S_TX_RD_ADDR: begin
          r_wait  <= '0;
          r_state <= S_TX_RD_WAIT;
        end
        S_TX_RD_WAIT: begin
          if (r_wait == WAIT_W'(SRAM_RD_LAT - 1)) begin
            r_word      <= SRAM_read_data;
            r_hi_loaded <= 1'b0;
            r_state     <= S_TX_SEND_HI;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_TX_SEND_HI: begin
          if (!r_hi_loaded) begin
            r_hi_loaded <= 1'b1;
          end else if (w_ready) begin
            r_state <= S_TX_SEND_LO;
          end
        end
        S_TX_SEND_LO: begin
          if (w_ready) begin
            r_remaining <= r_remaining - ADDR_W'(1);
            if (r_remaining != ADDR_W'(1)) begin
              r_sram_address <= r_sram_address + ADDR_W'(1);
              r_state        <= S_TX_RD_ADDR;
            end else begin
`ifdef UART_TX_CHECKSUM_EN
              r_state <= S_TX_CHKSUM;
`else
              r_state <= S_TX_DONE;
`endif
            end
          end
        end
`ifdef UART_TX_CHECKSUM_EN
        S_TX_CHKSUM: begin
          if (w_ready) r_state <= S_TX_DONE;
        end
`endif
        S_TX_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_TX_IDLE;
        end
        default: r_state <= S_TX_IDLE;
      endcase
`ifdef UART_TX_CHECKSUM_EN
      if (w_load && !w_load_chk) r_sum <= r_sum + w_tx_data;
`endif
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .Clock (Clock),
    .Reset (Reset),
    .Load  (w_load),
    .Data  (w_tx_data),
    .Tx    (w_tx),
    .Ready (w_ready)
  );

  assign SRAM_address = r_sram_address;
  assign SRAM_we_n    = 1'b1;
  assign UART_TX_O    = w_tx;
  assign Busy         = r_busy;
  assign Done         = r_done;

endmodule

// File: tb/tb_sram_uart_tx_dump.sv
// Bench for sram_uart_tx_dump: table of dumps, UART monitor with byte scoreboard,
// plus hand-written mid-byte reset sequence.
module tb_sram_uart_tx_dump;

  localparam int CPB = 4;
`ifdef UART_TX_CHECKSUM_EN
  localparam int CHK_EXTRA = 40;
`else
  localparam int CHK_EXTRA = 0;
`endif

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [17:0] Base_address = '0;
  logic [17:0] Word_count = '0;
  logic [15:0] SRAM_read_data = '0;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n;
  logic        UART_TX_O;
  logic        Busy;
  logic        Done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0      = 0;
  bit mon_en  = 1'b0;

  logic [7:0] exp_q[$];
  int         exp_t[$];

  typedef struct {
    logic [17:0] base;
    logic [17:0] count;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] w2;
    int          poke;
    int          lat;
  } vec_t;

  sram_uart_tx_dump #(.CLKS_PER_BIT(CPB), .SRAM_RD_LAT(2)) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .Start          (Start),
    .Base_address   (Base_address),
    .Word_count     (Word_count),
    .SRAM_read_data (SRAM_read_data),
    .SRAM_address   (SRAM_address),
    .SRAM_we_n      (SRAM_we_n),
    .UART_TX_O      (UART_TX_O),
    .Busy           (Busy),
    .Done           (Done)
  );

  initial forever #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  // SRAM model: data valid two cycles after the address
  logic [15:0] mem [logic [17:0]];
  logic [15:0] sram_p1 = '0;
  always @(posedge Clock) begin
    sram_p1        <= mem.exists(SRAM_address) ? mem[SRAM_address] : 16'h0000;
    SRAM_read_data <= sram_p1;
  end

  task automatic check(input string name, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // UART monitor: mid-bit sampling, compare each byte against the scoreboard
  initial begin : monitor
    logic [7:0] b;
    int         ts;
    int         et;
    logic [7:0] eb;
    bit         ok;
    forever begin
      @(negedge Clock);
      if (mon_en && UART_TX_O == 1'b0) begin
        ts = cyc;
        ok = 1'b1;
        b  = '0;
        repeat (CPB / 2) @(negedge Clock);
        if (UART_TX_O != 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge Clock);
          b[i] = UART_TX_O;
        end
        repeat (CPB) @(negedge Clock);
        if (UART_TX_O != 1'b1) ok = 1'b0;
        repeat (CPB / 2 - 1) @(negedge Clock);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_byte: got 0x%0h at cycle %0d, none required", b, ts - t0);
        end else begin
          eb = exp_q.pop_front();
          et = exp_t.pop_front();
          check("byte_value", b, eb);
          check("byte_start_cycle", ts - t0, et);
          check("byte_framing", ok, 1);
        end
      end
    end
  end

  task automatic run_dump(input vec_t v, input int idx);
    logic [15:0] w;
    logic [7:0]  sum = '0;
    logic [17:0] exp_a[$];
    logic [17:0] got_a[$];
    logic [17:0] last_a;
    int          n;
    int          done_cnt = 0;
    int          done_at  = -1;
    int          busy_bad = 0;
    n = int'(v.count);
    exp_q.delete();
    exp_t.delete();
    for (int i = 0; i < n; i++) begin
      w = (i == 0) ? v.w0 : (i == 1) ? v.w1 : v.w2;
      mem[18'(v.base + 18'(i))] = w;
      exp_q.push_back(w[15:8]); exp_t.push_back(5 + i * 84);
      exp_q.push_back(w[7:0]);  exp_t.push_back(45 + i * 84);
      sum = 8'(sum + w[15:8] + w[7:0]);
      exp_a.push_back(18'(v.base + 18'(i)));
    end
    if (n == 0) exp_a.push_back(v.base);
`ifdef UART_TX_CHECKSUM_EN
    exp_q.push_back(sum); exp_t.push_back(84 * n + 1);
`endif
    last_a = SRAM_address;
    @(negedge Clock);
    Base_address = v.base;
    Word_count   = v.count;
    Start        = 1'b1;
    t0           = cyc;
    for (int k = 1; k <= v.lat + 8; k++) begin
      @(negedge Clock);
      Start = 1'b0;
      if (v.poke != 0 && k == v.poke) begin
        Start        = 1'b1;
        Base_address = 18'h00200;
        Word_count   = 18'd1;
      end
      if (SRAM_address != last_a) begin
        got_a.push_back(SRAM_address);
        last_a = SRAM_address;
      end
      if (Done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (Busy != (k < v.lat)) busy_bad++;
      if (SRAM_we_n != 1'b1) busy_bad++;
    end
    Start = 1'b0;
    check($sformatf("v%0d_done_latency", idx), done_at, v.lat);
    check($sformatf("v%0d_done_pulses", idx), done_cnt, 1);
    check($sformatf("v%0d_busy_window_errors", idx), busy_bad, 0);
    check($sformatf("v%0d_bytes_missing", idx), exp_q.size(), 0);
    check($sformatf("v%0d_addr_count", idx), got_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++)
      check($sformatf("v%0d_addr%0d", idx, i), got_a[i], exp_a[i]);
  endtask

  initial begin : main
    vec_t vecs[6];
    int   bad;
    vecs[0] = '{18'h00100, 18'd1, 16'hA55A, 16'h0000, 16'h0000, 0, 86 + CHK_EXTRA};
    vecs[1] = '{18'h3FFFF, 18'd2, 16'h1234, 16'hABCD, 16'h0000, 0, 170 + CHK_EXTRA};
    vecs[2] = '{18'h00050, 18'd0, 16'h0000, 16'h0000, 16'h0000, 0, 2 + CHK_EXTRA};
    vecs[3] = '{18'h00300, 18'd3, 16'h1111, 16'h2222, 16'h3333, 50, 254 + CHK_EXTRA};
    vecs[4] = '{18'h00400, 18'd2, 16'h0102, 16'hFFFF, 16'h0000, 0, 170 + CHK_EXTRA};
    vecs[5] = '{18'h00500, 18'd1, 16'h00FF, 16'h0000, 16'h0000, 86 + CHK_EXTRA, 86 + CHK_EXTRA};

    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    check("reset_tx", UART_TX_O, 1);
    check("reset_busy", Busy, 0);
    check("reset_done", Done, 0);
    check("reset_we_n", SRAM_we_n, 1);
    check("reset_addr", SRAM_address, 0);
    Reset = 1'b0;

    // Reset in the middle of a start bit
    mem[18'h00100] = 16'hA55A;
    @(negedge Clock);
    Base_address = 18'h00100;
    Word_count   = 18'd1;
    Start        = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (5) @(negedge Clock);
    check("midbyte_line_low", UART_TX_O, 0);
    check("midbyte_busy", Busy, 1);
    Reset = 1'b1;
    @(negedge Clock);
    check("abort_tx", UART_TX_O, 1);
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    check("abort_we_n", SRAM_we_n, 1);
    check("abort_addr", SRAM_address, 0);
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    bad = 0;
    repeat (60) begin
      @(negedge Clock);
      if (UART_TX_O != 1'b1 || Busy != 1'b0 || Done != 1'b0) bad++;
    end
    check("quiet_after_abort", bad, 0);

    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) run_dump(vecs[i], i);

    repeat (20) @(negedge Clock);
    check("final_bytes_pending", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
